dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
- REQ-001: Parameter DEPTH_WORDS, default 256: number of 32-bit storage words.
- REQ-002: Parameter WAIT_CYCLES, default 2: wait states inserted per access, range 0..15.
- REQ-003: clk  in  1  single clock; all state changes on the rising edge.
- REQ-004: rst_n  in  1  asynchronous, active-low reset.
- REQ-005: req_valid  in  1  initiator presents a request.
- REQ-006: req_ready  out  1  responder accepts a request this cycle.
- REQ-007: req_we  in  1  1 = store, 0 = load.
- REQ-008: req_addr  in  32  byte address.
- REQ-009: req_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- REQ-010: req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- REQ-011: req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- REQ-012: rsp_valid  out  1  response available.
- REQ-013: rsp_ready  in  1  initiator accepts the response.
- REQ-014: rsp_rdata  out  32  load data, right-aligned and extended; 0 for stores and errors.
- REQ-015: rsp_err  out  1  request was misaligned, out of range, or illegal size.

Function
- REQ-016: The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
- REQ-017: req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid = 1 and req_ready = 1.
- REQ-018: On acceptance, the block SHALL latch we, addr, size, unsigned and wdata, load the wait counter with WAIT_CYCLES, and enter WAIT; request inputs are ignored until the next return to IDLE.
- REQ-019: In WAIT with counter ≠ 0, the counter SHALL decrement each cycle.
- REQ-020: In WAIT with counter = 0, the block SHALL perform the access on that edge and enter RESP.
- REQ-021: rsp_valid therefore rises exactly WAIT_CYCLES+1 edges after the accept edge.
- REQ-022: In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be 1 / stable until an edge with rsp_ready = 1; on that edge the block returns to IDLE.
- REQ-023: rsp_ready is ignored outside RESP.
- REQ-024: Byte order SHALL be little-endian. Word index = addr[31:2] and byte lane = addr[1:0].
- REQ-025: A store SHALL modify only the addressed lanes: byte → lane addr[1:0]; half → lanes addr[1]*2 and addr[1]*2+1; word → all 4 lanes.
- REQ-026: A load SHALL extract the addressed lanes, then zero-extend (req_unsigned = 1) or sign-extend from bit 7/15 (req_unsigned = 0) to 32 bits. A word load ignores req_unsigned.
- REQ-027: An error SHALL be flagged on any of the following:
  - half access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0;
  - addr ≥ 4*DEPTH_WORDS;
  - size = 11.
- REQ-028: An errored request SHALL take the same latency as a normal one, SHALL NOT modify storage, and SHALL return rsp_rdata = 0 with rsp_err = 1.
- REQ-029: A store response SHALL return rsp_rdata = 0 and rsp_err = 0 when legal.
- REQ-030: The next request may be accepted no earlier than the edge after the response handshake; no pipelining (1 outstanding request maximum).

Reset
- REQ-031: While rst_n = 0, state SHALL be IDLE and the counter 0; outputs SHALL be req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- REQ-032: req_ready SHALL first be 1 in the first cycle after rst_n deasserts.
- REQ-033: Reset asserted during WAIT SHALL abandon the request: a pending store is not performed and no response is issued.
- REQ-034: Reset asserted during RESP SHALL drop the response.
- REQ-035: Storage contents SHALL NOT be altered by reset.

Verification
- REQ-036: Word store then load, WAIT_CYCLES = 2: store 0xDEADBEEF at 0x10, then load word from 0x10 → rsp_rdata = 0xDEADBEEF, rsp_err = 0. Each rsp_valid rises 3 edges after its accept edge.
- REQ-037: Sub-word access after the REQ-036 store:
  - byte load signed at 0x13 → 0xFFFFFFDE;
  - byte load unsigned at 0x13 → 0x000000DE;
  - half load signed at 0x12 → 0xFFFFDEAD;
  - byte store 0x55 at 0x11, then word load at 0x10 → 0xDEAD55EF.
- REQ-038: Errors:
  - half load at 0x11 → rsp_err = 1, rdata = 0;
  - word store 0x12345678 at 0x12 → rsp_err = 1, and a later word load at 0x10 is unchanged;
  - load at 4*DEPTH_WORDS → rsp_err = 1;
  - size = 11 → rsp_err = 1.
- REQ-039: Back-pressure: hold rsp_ready = 0 for 5 cycles in RESP → rsp_valid and rsp_rdata stay stable and req_ready stays 0. Raise rsp_ready → IDLE next edge, and a back-to-back request is accepted on the following edge.
- REQ-040: WAIT_CYCLES = 0 → rsp_valid rises 1 edge after acceptance.
- REQ-041: Reset during WAIT of a store of 0xCAFEF00D to 0x20 (prior value 0x0) → no response is issued, and after reset a word load of 0x20 returns 0x00000000.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with wait states and access checking
//
// Purpose:
//   Word-organised little-endian data memory behind a valid/ready request
//   channel and a valid/ready response channel. Each accepted request is held
//   for WAIT_CYCLES wait states, then performed (or rejected as an error). The
//   result is presented until the initiator takes it. Only one request is in
//   flight at a time.
//
// Parameters:
//   DEPTH_WORDS   number of 32-bit storage words
//   WAIT_CYCLES   wait states per access (0..15)
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset (storage is not cleared)
//   req_valid     request present
//   req_ready     request accepted this cycle (IDLE only)
//   req_we        1 = store, 0 = load
//   req_addr      byte address
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  load extension: 1 zero-extend, 0 sign-extend
//   req_wdata     right-aligned store data
//   rsp_valid     response present (RESP only)
//   rsp_ready     response accepted
//   rsp_rdata     right-aligned, extended load data; 0 for stores and errors
//   rsp_err       misaligned, out of range or illegal size

module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        we_q,    we_d;
    logic [31:0] addr_q,  addr_d;
    logic [1:0]  size_q,  size_d;
    logic        uns_q,   uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             acc_err;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic [31:0]      rd_word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_data;
    logic [3:0]       lane_en;
    logic [31:0]      wr_data;
    logic             mem_we;

    // Access decode works entirely from the latched request, so the request
    // inputs may change freely once the request has been accepted.
    always_comb begin
        lane     = addr_q[1:0];
        word_idx = addr_q[IDX_W+1:2];

        acc_err = 1'b0;
        if (size_q == 2'b11)                         acc_err = 1'b1;
        if (size_q == 2'b01 && addr_q[0])            acc_err = 1'b1;
        if (size_q == 2'b10 && addr_q[1:0] != 2'b00) acc_err = 1'b1;
        if ({1'b0, addr_q} >= ADDR_LIMIT)            acc_err = 1'b1;

        rd_word  = mem_q[word_idx];
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = rd_word[{lane[1], 4'b0000} +: 16];

        case (size_q)
            2'b00:   load_data = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase

        // Store data is replicated across lanes so each enabled lane picks up
        // the right-aligned source bits without a barrel shift.
        case (size_q)
            2'b00: begin
                lane_en = 4'b0001 << lane;
                wr_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_en = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = (acc_err || we_q) ? 32'd0 : load_data;
                    err_d   = acc_err;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    // Clearing here keeps rsp_rdata/rsp_err at 0 whenever no
                    // response is being presented.
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        // Gated by rst_n so the responder does not advertise readiness while
        // reset is held, even though the state register already reads IDLE.
        req_ready = rst_n && (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        mem_we    = (state_q == S_WAIT) && (cnt_q == 4'd0) && we_q && !acc_err;
    end

    // Storage has no reset; its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder against a byte-array reference model

module tb_dmem_responder;

    localparam int DEPTH  = 256;
    localparam int WAIT_A = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b0;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0] rsp_rdata_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_rdata_b;

    int tests = 0;
    int fails = 0;

    bit [7:0] mdl [0:4*DEPTH-1];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    // Zero-wait instance driven by the same request stream; it finishes early
    // and then waits in RESP until the shared handshake.
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array, access = list of consecutive bytes.
    function automatic void model(input bit we, input logic [31:0] addr, input logic [1:0] size,
                                  input bit uns, input logic [31:0] wd,
                                  output bit err, output logic [31:0] rd);
        int n;
        n   = 1 << size;
        err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'(4*DEPTH));
        rd  = 32'd0;
        if (err) return;
        for (int i = 0; i < n; i++) begin
            if (we) mdl[int'(addr) + i] = wd[8*i +: 8];
            else    rd[8*i +: 8] = mdl[int'(addr) + i];
        end
        if (!we && !uns && size == 2'b00 && rd[7])  rd[31:8]  = 24'hFFFFFF;
        if (!we && !uns && size == 2'b01 && rd[15]) rd[31:16] = 16'hFFFF;
    endfunction

    // Called at a negedge with both DUTs idle; returns at a negedge, both idle.
    task automatic txn(input string tag, input bit we, input logic [31:0] addr,
                       input logic [1:0] size, input bit uns, input logic [31:0] wd,
                       input int hold, output logic [31:0] got_rd, output logic got_err);
        bit          eerr;
        logic [31:0] erd;
        int          lat_a, lat_b;
        model(we, addr, size, uns, wd, eerr, erd);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd; rsp_ready = 1'b0;
        check({tag, " req_ready_a"}, 32'(req_ready_a), 32'd1);
        check({tag, " req_ready_b"}, 32'(req_ready_b), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_wdata = $urandom;
        lat_a = 0;
        lat_b = rsp_valid_b ? 0 : -1;
        while (!rsp_valid_a && lat_a < 40) begin
            @(negedge clk);
            lat_a++;
            if (lat_b < 0 && rsp_valid_b) lat_b = lat_a;
        end
        check({tag, " latency_a"}, 32'(lat_a), 32'(WAIT_A + 1));
        check({tag, " latency_b"}, 32'(lat_b), 32'd1);
        check({tag, " rdata_a"}, rsp_rdata_a, erd);
        check({tag, " err_a"}, 32'(rsp_err_a), 32'(eerr));
        check({tag, " rdata_b"}, rsp_rdata_b, erd);
        check({tag, " err_b"}, 32'(rsp_err_b), 32'(eerr));
        got_rd  = rsp_rdata_a;
        got_err = rsp_err_a;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " hold valid_a"}, 32'(rsp_valid_a), 32'd1);
            check({tag, " hold rdata_a"}, rsp_rdata_a, erd);
            check({tag, " hold err_a"}, 32'(rsp_err_a), 32'(eerr));
            check({tag, " hold req_ready_a"}, 32'(req_ready_a), 32'd0);
            check({tag, " hold valid_b"}, 32'(rsp_valid_b), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " post valid_a"}, 32'(rsp_valid_a), 32'd0);
        check({tag, " post req_ready_a"}, 32'(req_ready_a), 32'd1);
        check({tag, " post req_ready_b"}, 32'(req_ready_b), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w, lat;
        logic [1:0]  sz;
        logic [31:0] ad;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset req_ready_a", 32'(req_ready_a), 32'd0);
        check("reset rsp_valid_a", 32'(rsp_valid_a), 32'd0);
        check("reset rsp_rdata_a", rsp_rdata_a, 32'd0);
        check("reset rsp_err_a",   32'(rsp_err_a), 32'd0);
        check("reset req_ready_b", 32'(req_ready_b), 32'd0);
        rst_n = 1'b1;
        #1;
        check("first ready_a", 32'(req_ready_a), 32'd1);
        check("first ready_b", 32'(req_ready_b), 32'd1);
        @(negedge clk);

        // Bring storage to a known state
        for (int i = 0; i < DEPTH; i++) begin
            txn("init", 1'b1, 32'(4*i), 2'b10, 1'b0, 32'd0, 0, rd, er);
        end

        // Word store then load
        txn("st_word", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, rd, er);
        check("st_word rdata", rd, 32'd0);
        txn("ld_word", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("ld_word const", rd, 32'hDEADBEEF);
        check("ld_word err", 32'(er), 32'd0);

        // Sub-word accesses
        txn("ld_b_s", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 1, rd, er);
        check("ld_b_s const", rd, 32'hFFFFFFDE);
        txn("ld_b_u", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, rd, er);
        check("ld_b_u const", rd, 32'h000000DE);
        txn("ld_h_s", 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 0, rd, er);
        check("ld_h_s const", rd, 32'hFFFFDEAD);
        txn("st_b", 1'b1, 32'h11, 2'b00, 1'b0, 32'hAAAAAA55, 0, rd, er);
        txn("ld_w2", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("ld_w2 const", rd, 32'hDEAD55EF);

        // Errors
        txn("err_half", 1'b0, 32'h11, 2'b01, 1'b0, 32'h0, 0, rd, er);
        check("err_half err", 32'(er), 32'd1);
        check("err_half rdata", rd, 32'd0);
        txn("err_st", 1'b1, 32'h12, 2'b10, 1'b0, 32'h12345678, 0, rd, er);
        check("err_st err", 32'(er), 32'd1);
        txn("ld_w3", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("ld_w3 const", rd, 32'hDEAD55EF);
        txn("err_range", 1'b0, 32'(4*DEPTH), 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("err_range err", 32'(er), 32'd1);
        txn("err_last_ok", 1'b0, 32'(4*DEPTH-1), 2'b00, 1'b1, 32'h0, 0, rd, er);
        check("err_last_ok err", 32'(er), 32'd0);
        txn("err_size", 1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 0, rd, er);
        check("err_size err", 32'(er), 32'd1);

        // Back-pressure, then back-to-back request
        txn("bp", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 5, rd, er);
        txn("b2b", 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 0, rd, er);
        check("b2b const", rd, 32'h0000DEAD);

        // Reset during RESP drops the response
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid_a && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("rresp reached", 32'(rsp_valid_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rresp valid_a", 32'(rsp_valid_a), 32'd0);
        check("rresp rdata_a", rsp_rdata_a, 32'd0);
        check("rresp ready_a", 32'(req_ready_a), 32'd0);
        check("rresp valid_b", 32'(rsp_valid_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during WAIT abandons a store
        txn("pre20", 1'b1, 32'h20, 2'b10, 1'b0, 32'h0, 0, rd, er);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10;
        req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rwait ready_a", 32'(req_ready_a), 32'd0);
        check("rwait valid_a", 32'(rsp_valid_a), 32'd0);
        check("rwait err_a", 32'(rsp_err_a), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rwait release ready_a", 32'(req_ready_a), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rwait no rsp_a", 32'(rsp_valid_a), 32'd0);
            check("rwait no rsp_b", 32'(rsp_valid_b), 32'd0);
        end
        txn("ld20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("ld20 const", rd, 32'h00000000);

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom_range(0, 3));
            w  = $urandom_range(0, DEPTH);
            ad = 32'(4*w) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) ad[0] = 1'b0;
                if (sz == 2'b10) ad[1:0] = 2'b00;
            end
            txn($sformatf("rnd%0d", i), 1'($urandom), ad, sz, 1'($urandom), $urandom,
                $urandom_range(0, 2), rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
